x25519_op_scheduler: RTL and testbench
======================================

# x25519_op_scheduler

Two-requester scheduler that owns one X25519_ScalarMult core and shares it between two clients. Accepts whole operations: ECDH scalar multiply, expanded-point scalar multiply, or base-point scalar multiply. Sequences the core's load/start/readback strobes and returns results as a 256-bit beat stream. Sits between the crypto clients (APB wrapper, key-exchange engine) and the core, replacing per-client direct wiring of the core.

## Interface
- RD_LATENCY, 2: cycles from `core_dsa_rd` to valid `core_work_out`; legal range 1..7.
- Ports, clock and reset first:
  - `clk` in 1: clock.
  - `rst_n` in 1: reset, asynchronous, active-low.
  - `req_valid` in 2: per-requester operation request.
  - `req_ready` out 2: per-requester accept strobe.
  - `req_cmd` in 2x2: operation code. 0 = DH, 1 = scalarmult, 2 = scalarbase, 3 = illegal.
  - `req_e` in 2x256: scalar.
  - `req_a` in 2x256: DH work point, or Q block 0.
  - `req_b` in 2x256: Q block 1 (scalarmult only).
  - `rsp_valid` out 1: response beat valid.
  - `rsp_ready` in 1: response beat accepted.
  - `rsp_id` out 1: requester index the beat belongs to.
  - `rsp_data` out 256: result word.
  - `rsp_last` out 1: final beat of the response.
  - `rsp_err` out 1: illegal command.
  - `core_e` out 256: to core `e`.
  - `core_work_in` out 256: to core `work_in`.
  - `core_dh_en` out 1: to core `dh_en`.
  - `core_dsa_en` out 1: to core `dsa_en`.
  - `core_dsa_base_en` out 1: to core `dsa_base_en`.
  - `core_dsa_load` out 1: to core `dsa_load`.
  - `core_dsa_rd` out 1: to core `dsa_rd`.
  - `core_dsa_addr` out 2: to core `dsa_addr`.
  - `core_out_valid` in 1: from core.
  - `core_dsa_done` in 1: from core.
  - `core_work_out` in 256: from core.
  - `busy` out 1: FSM not in IDLE.
  - `last_cycles` out 32: cycle count of the last completed core operation.

## Operation
- FSM states are IDLE, LOAD, LOAD_Q1, WAIT, RD, RDWAIT and RESP.
- All core strobes are Moore outputs of the state register and are high for exactly one cycle.
- IDLE arbitration:
  - Round-robin. `last_grant` resets to 1, so requester 0 wins the first tie.
  - With one valid requester, that requester is granted.
  - `req_ready[g]` = IDLE & `req_valid[g]` & granted. This is the only combinational path.
  - On the handshake: latch cmd/e/a/b and `g`, update `last_grant`, then go to LOAD.
  - Requesters hold `req_valid` and their data stable until `req_ready`.
- LOAD:
  - Always drive `core_e` = latched e and `core_work_in` = latched a.
  - cmd 0: `core_dh_en`, then WAIT.
  - cmd 1: `core_dsa_load` with addr 0, then LOAD_Q1.
  - cmd 2: `core_dsa_load` and `core_dsa_base_en` with addr 0, then WAIT.
  - cmd 3: no strobes. Go to RESP with data 0, err=1, last=1.
- LOAD_Q1: `core_work_in` = latched b, addr 1, `core_dsa_load` and `core_dsa_en`; then WAIT.
- `core_e` holds the latched e from LOAD until the next grant.
- `core_work_in` shows b only in LOAD_Q1 and a otherwise.
- WAIT:
  - cmd 0 waits for `core_out_valid`. Capture `core_work_out`, set last=1, go to RESP.
  - cmd 1 and cmd 2 wait for `core_dsa_done`. Set idx=0 and go to RD.
  - Done/valid pulses outside WAIT are ignored. A pulse of the wrong type in WAIT is ignored.
- RD: `core_dsa_rd` with `core_dsa_addr` = idx; then RDWAIT.
- RDWAIT: count RD_LATENCY-1 cycles. On the final cycle, capture `core_work_out` and set last = (idx==3). Then RESP.
- RESP:
  - `rsp_valid`=1 with data/id/last/err stable until `rsp_ready`.
  - On the handshake: if last, go to IDLE; else idx+1 and go to RD.
- `last_cycles`:
  - An internal counter clears on LOAD entry and increments every cycle through WAIT exit.
  - It saturates at 0xFFFFFFFF.
  - Its value is copied to `last_cycles` on WAIT exit.
  - Illegal commands do not update it.

## Timing
- Reset values:
  - All strobes, `rsp_*`, `req_ready`, `busy` and `last_cycles` = 0.
  - `core_dsa_addr` = 0; `core_e` and `core_work_in` = 0; FSM = IDLE.
- Start latency:
  - Grant handshake at cycle N puts LOAD at N+1, so `core_dh_en`/`core_dsa_load` are high in N+1.
  - For scalarmult, LOAD_Q1 is N+2.
- DH completion: `core_out_valid` at cycle M gives `rsp_valid` at M+1.
- Readback:
  - `core_dsa_done` at M gives RD at M+1.
  - Capture at M+1+RD_LATENCY; `rsp_valid` the following cycle.
  - Each later beat comes RD_LATENCY+1 cycles after the previous `rsp_ready` handshake.
- Response order:
  - DH: 1 beat.
  - scalarmult/scalarbase: 4 beats, addr 0..3; last on addr 3.
  - illegal: 1 beat, err.
- Back-to-back: a RESP final handshake at cycle K means IDLE at K+1, with a grant possible in K+1.
- Reset mid-operation: returns to IDLE immediately and drops `rsp_valid`. The core must be reset with the same `rst_n`. Stale done pulses after reset are ignored.

## Test plan
- DH from requester 0:
  - Stimulus: e=9, a=0x1234, cmd 0; model returns out_valid 20 cycles after `dh_en`.
  - Required: `dh_en` one cycle at N+1; 1 beat with id=0, last=1, err=0, data = model result; `last_cycles`=21.
- Scalarmult from requester 1:
  - Required: `dsa_load` addr 0 at N+1, work_in=a.
  - Then `dsa_load`+`dsa_en` addr 1 at N+2, work_in=b.
  - After done: 4 `dsa_rd` pulses, addr 0,1,2,3; 4 beats, last on the 4th; RD_LATENCY=2 spacing checked.
- Both `req_valid` high continuously with cmd 2: grants alternate 0,1,0,1; no beat has the wrong `rsp_id`; first grant to 0.
- cmd 3: no core strobe ever asserts; 1 beat with err=1, data=0; `last_cycles` unchanged.
- Hold `rsp_ready` low 10 cycles: `rsp_valid`/data stable, no `dsa_rd` issued until the handshake.
- Assert `rst_n` low during WAIT:
  - All outputs return to reset values asynchronously; a `dsa_done` pulse after release is ignored.
  - Next request completes normally.

Source files
------------

// File: rtl/x25519_op_scheduler.sv
// Shares one X25519 scalar-multiply core between two requesters: round-robin grants whole
// operations, drives the core load/start/readback strobes and streams results as 256-bit beats.
module x25519_op_scheduler #(
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0][1:0]   req_cmd,
  input  logic [1:0][255:0] req_e,
  input  logic [1:0][255:0] req_a,
  input  logic [1:0][255:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [255:0]      rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [255:0]      core_e,
  output logic [255:0]      core_work_in,
  output logic              core_dh_en,
  output logic              core_dsa_en,
  output logic              core_dsa_base_en,
  output logic              core_dsa_load,
  output logic              core_dsa_rd,
  output logic [1:0]        core_dsa_addr,
  input  logic              core_out_valid,
  input  logic              core_dsa_done,
  input  logic [255:0]      core_work_out,
  output logic              busy,
  output logic [31:0]       last_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_LOAD_Q1, ST_WAIT, ST_RD, ST_RDWAIT, ST_RESP
  } state_t;

  localparam logic [1:0] CMD_DH = 2'd0;
  localparam logic [1:0] CMD_SM = 2'd1;
  localparam logic [1:0] CMD_SB = 2'd2;
  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_t        state_r;
  logic [1:0]    cmd_r;
  logic [255:0]  e_r;
  logic [255:0]  a_r;
  logic [255:0]  b_r;
  logic          id_r;
  logic          last_grant_r;
  logic [1:0]    idx_r;
  logic [2:0]    lat_cnt_r;
  logic [31:0]   cyc_cnt_r;
  logic [31:0]   last_cycles_r;
  logic          rsp_valid_r;
  logic [255:0]  rsp_data_r;
  logic          rsp_last_r;
  logic          rsp_err_r;
  logic          dh_en_r;
  logic          dsa_en_r;
  logic          base_en_r;
  logic          load_r;
  logic          rd_r;
  logic [1:0]    addr_r;
  logic          grant_s;
  logic          hs_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Round-robin pick: on a tie the requester that did not win last time goes next
  always_comb begin
    grant_s = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_s = ~last_grant_r;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign hs_s = (state_r == ST_IDLE) && req_valid[grant_s];

  // Accept strobe for the granted requester, only while idle
  always_comb begin
    req_ready = 2'b00;
    if (hs_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Operation sequencer; strobes are set on the transition into the state that owns them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cmd_r         <= 2'd0;
      e_r           <= 256'd0;
      a_r           <= 256'd0;
      b_r           <= 256'd0;
      id_r          <= 1'b0;
      last_grant_r  <= 1'b1;
      idx_r         <= 2'd0;
      lat_cnt_r     <= 3'd0;
      cyc_cnt_r     <= 32'd0;
      last_cycles_r <= 32'd0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 256'd0;
      rsp_last_r    <= 1'b0;
      rsp_err_r     <= 1'b0;
      dh_en_r       <= 1'b0;
      dsa_en_r      <= 1'b0;
      base_en_r     <= 1'b0;
      load_r        <= 1'b0;
      rd_r          <= 1'b0;
      addr_r        <= 2'd0;
    end else begin
      dh_en_r   <= 1'b0;
      dsa_en_r  <= 1'b0;
      base_en_r <= 1'b0;
      load_r    <= 1'b0;
      rd_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            cmd_r        <= req_cmd[grant_s];
            e_r          <= req_e[grant_s];
            a_r          <= req_a[grant_s];
            b_r          <= req_b[grant_s];
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            cyc_cnt_r    <= 32'd0;
            addr_r       <= 2'd0;
            dh_en_r      <= (req_cmd[grant_s] == CMD_DH);
            load_r       <= (req_cmd[grant_s] == CMD_SM) || (req_cmd[grant_s] == CMD_SB);
            base_en_r    <= (req_cmd[grant_s] == CMD_SB);
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cyc_cnt_r <= sat_inc(cyc_cnt_r);
          case (cmd_r)
            CMD_DH, CMD_SB: state_r <= ST_WAIT;
            CMD_SM: begin
              load_r   <= 1'b1;
              dsa_en_r <= 1'b1;
              addr_r   <= 2'd1;
              state_r  <= ST_LOAD_Q1;
            end
            default: begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= 256'd0;
              rsp_last_r  <= 1'b1;
              rsp_err_r   <= 1'b1;
              state_r     <= ST_RESP;
            end
          endcase
        end
        ST_LOAD_Q1: begin
          cyc_cnt_r <= sat_inc(cyc_cnt_r);
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          cyc_cnt_r <= sat_inc(cyc_cnt_r);
          if (cmd_r == CMD_DH) begin
            if (core_out_valid) begin
              rsp_valid_r   <= 1'b1;
              rsp_data_r    <= core_work_out;
              rsp_last_r    <= 1'b1;
              rsp_err_r     <= 1'b0;
              last_cycles_r <= sat_inc(cyc_cnt_r);
              state_r       <= ST_RESP;
            end
          end else if (core_dsa_done) begin
            idx_r         <= 2'd0;
            rd_r          <= 1'b1;
            addr_r        <= 2'd0;
            last_cycles_r <= sat_inc(cyc_cnt_r);
            state_r       <= ST_RD;
          end
        end
        ST_RD: begin
          lat_cnt_r <= 3'd0;
          state_r   <= ST_RDWAIT;
        end
        ST_RDWAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= core_work_out;
            rsp_last_r  <= (idx_r == 2'd3);
            rsp_err_r   <= 1'b0;
            state_r     <= ST_RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (rsp_last_r) begin
              state_r <= ST_IDLE;
            end else begin
              idx_r   <= idx_r + 2'd1;
              rd_r    <= 1'b1;
              addr_r  <= idx_r + 2'd1;
              state_r <= ST_RD;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid        = rsp_valid_r;
  assign rsp_id           = id_r;
  assign rsp_data         = rsp_data_r;
  assign rsp_last         = rsp_last_r;
  assign rsp_err          = rsp_err_r;
  assign core_e           = e_r;
  // Q block 1 is only presented during its own load cycle
  assign core_work_in     = (state_r == ST_LOAD_Q1) ? b_r : a_r;
  assign core_dh_en       = dh_en_r;
  assign core_dsa_en      = dsa_en_r;
  assign core_dsa_base_en = base_en_r;
  assign core_dsa_load    = load_r;
  assign core_dsa_rd      = rd_r;
  assign core_dsa_addr    = addr_r;
  assign busy             = (state_r != ST_IDLE);
  assign last_cycles      = last_cycles_r;

endmodule

// File: tb/tb_x25519_op_scheduler.sv
// Directed bench for x25519_op_scheduler with a small behavioural core model
// (DH result 20 cycles after dh_en, done 8 cycles after the last load, 2-cycle readback).
module tb_x25519_op_scheduler;
  localparam int L = 2;
  localparam logic [255:0] DH_K = {8{32'hA5C3_0F96}};
  localparam logic [255:0] JUNK = {4{64'hDEAD_BEEF_0BAD_F00D}};

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready;
  logic [1:0][1:0] req_cmd;
  logic [1:0][255:0] req_e, req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_last, rsp_err;
  logic [255:0] rsp_data, core_e, core_work_in, core_work_out;
  logic core_dh_en, core_dsa_en, core_dsa_base_en, core_dsa_load, core_dsa_rd;
  logic [1:0] core_dsa_addr;
  logic core_out_valid, core_dsa_done, busy, inj_done;
  logic [31:0] last_cycles;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x25519_op_scheduler #(.RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_e(req_e), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .core_e(core_e), .core_work_in(core_work_in),
    .core_dh_en(core_dh_en), .core_dsa_en(core_dsa_en), .core_dsa_base_en(core_dsa_base_en),
    .core_dsa_load(core_dsa_load), .core_dsa_rd(core_dsa_rd), .core_dsa_addr(core_dsa_addr),
    .core_out_valid(core_out_valid), .core_dsa_done(core_dsa_done),
    .core_work_out(core_work_out), .busy(busy), .last_cycles(last_cycles)
  );

  // Core model
  int dh_cnt, dn_cnt;
  logic p1, p2;
  logic [1:0] a1, a2;
  logic [255:0] m_e, m_a, m_b, dh_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dh_cnt <= 0; dn_cnt <= 0; p1 <= 1'b0; p2 <= 1'b0; a1 <= 2'd0; a2 <= 2'd0;
      m_e <= 256'd0; m_a <= 256'd0; m_b <= 256'd0; dh_res <= 256'd0;
    end else begin
      p1 <= core_dsa_rd; a1 <= core_dsa_addr; p2 <= p1; a2 <= a1;
      if (dh_cnt != 0) dh_cnt <= dh_cnt - 1;
      if (dn_cnt != 0) dn_cnt <= dn_cnt - 1;
      if (core_dh_en) begin
        dh_cnt <= 20;
        dh_res <= core_e ^ core_work_in ^ DH_K;
      end
      if (core_dsa_load && core_dsa_addr == 2'd0) begin
        m_e <= core_e; m_a <= core_work_in; m_b <= 256'd0;
      end
      if (core_dsa_load && core_dsa_addr == 2'd1) m_b <= core_work_in;
      if (core_dsa_load && (core_dsa_base_en || (core_dsa_en && core_dsa_addr == 2'd1))) dn_cnt <= 8;
    end
  end

  assign core_out_valid = (dh_cnt == 1);
  assign core_dsa_done  = (dn_cnt == 1) | inj_done;
  assign core_work_out  = p2 ? (m_e + m_a + m_b + {254'd0, a2}) : ((dh_cnt == 1) ? dh_res : JUNK);

  // Event monitor
  typedef struct { int c; logic [1:0] addr; logic en; logic base; logic [255:0] win; } load_t;
  typedef struct { int c; logic id; logic [255:0] d; logic last; logic err; int start; } beat_t;
  load_t loads[$];
  beat_t beats[$];
  int rds_c[$], dh_c[$], done_c[$], grant_c[$];
  logic [1:0] rds_a[$];
  logic grant_id[$];
  int strobe_hits = 0;
  int doubles = 0;

  initial begin
    logic [4:0] sb, prev_sb;
    logic v_open;
    int v_start;
    prev_sb = 5'd0; v_open = 1'b0; v_start = 0;
    forever begin
      @(negedge clk);
      sb = {core_dh_en, core_dsa_en, core_dsa_base_en, core_dsa_load, core_dsa_rd};
      if (sb != 5'd0) strobe_hits++;
      doubles += $countones(sb & prev_sb & 5'b11101);
      prev_sb = sb;
      if (core_dh_en) dh_c.push_back(cyc);
      if (core_dsa_load) loads.push_back('{cyc, core_dsa_addr, core_dsa_en, core_dsa_base_en, core_work_in});
      if (core_dsa_rd) begin rds_c.push_back(cyc); rds_a.push_back(core_dsa_addr); end
      if (core_dsa_done) done_c.push_back(cyc);
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) begin grant_c.push_back(cyc); grant_id.push_back(i[0]); end
      if (!rsp_valid) v_open = 1'b0;
      else if (!v_open) begin v_open = 1'b1; v_start = cyc; end
      if (rsp_valid && rsp_ready) begin
        beats.push_back('{cyc, rsp_id, rsp_data, rsp_last, rsp_err, v_start});
        v_open = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int id, input logic [1:0] cmd, input logic [255:0] e, a, b, output int gc);
    req_cmd[id] = cmd; req_e[id] = e; req_a[id] = a; req_b[id] = b; req_valid[id] = 1'b1;
    gc = -1;
    for (int n = 0; n < 200 && gc < 0; n++) begin
      @(negedge clk);
      if (req_ready[id]) gc = cyc;
      tick();
    end
    req_valid[id] = 1'b0;
    n_vec++;
    if (gc < 0) begin n_err++; $display("FAIL grant_timeout id=%0d got no grant, required within 200 cycles", id); end
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int k = 0; k < bound && beats.size() < n; k++) @(negedge clk);
    tick();
    n_vec++;
    if (beats.size() < n) begin n_err++; $display("FAIL beat_timeout got %0d beats, required %0d", beats.size(), n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({core_dh_en, core_dsa_en, core_dsa_base_en, core_dsa_load, core_dsa_rd} !== 5'd0) begin n_err++; $display("FAIL reset_strobes got nonzero, required 0"); end
    n_vec++; if ({rsp_valid, rsp_last, rsp_err, req_ready, busy} !== 6'd0) begin n_err++; $display("FAIL reset_ctrl got %b, required 0", {rsp_valid, rsp_last, rsp_err, req_ready, busy}); end
    n_vec++; if (last_cycles !== 32'd0) begin n_err++; $display("FAIL reset_last_cycles got %0d, required 0", last_cycles); end
    n_vec++; if (core_e !== 256'd0 || core_work_in !== 256'd0 || core_dsa_addr !== 2'd0) begin n_err++; $display("FAIL reset_core_bus got nonzero, required 0"); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dh();
    int gc, b0, d0, l0, r0;
    b0 = beats.size(); d0 = dh_c.size(); l0 = loads.size(); r0 = rds_c.size();
    do_req(0, 2'd0, 256'd9, 256'h1234, 256'd0, gc);
    wait_beats(b0 + 1, 100);
    n_vec++; if (dh_c.size() != d0 + 1 || dh_c[d0] != gc + 1) begin n_err++; $display("FAIL dh_en_timing got %0d pulses first at %0d, required 1 at %0d", dh_c.size() - d0, dh_c[d0], gc + 1); end
    n_vec++; if ({beats[b0].id, beats[b0].last, beats[b0].err} !== 3'b010) begin n_err++; $display("FAIL dh_flags got id/last/err %b, required 010", {beats[b0].id, beats[b0].last, beats[b0].err}); end
    n_vec++; if (beats[b0].d !== (256'd9 ^ 256'h1234 ^ DH_K)) begin n_err++; $display("FAIL dh_data got %h, required %h", beats[b0].d, 256'd9 ^ 256'h1234 ^ DH_K); end
    n_vec++; if (beats[b0].start != gc + 22) begin n_err++; $display("FAIL dh_rsp_timing got cycle %0d, required %0d", beats[b0].start, gc + 22); end
    n_vec++; if (last_cycles !== 32'd21) begin n_err++; $display("FAIL dh_last_cycles got %0d, required 21", last_cycles); end
    n_vec++; if (loads.size() != l0 || rds_c.size() != r0) begin n_err++; $display("FAIL dh_no_dsa got %0d loads %0d reads, required 0", loads.size() - l0, rds_c.size() - r0); end
  endtask

  task automatic test_scalarmult();
    int gc, b0, l0, r0, dn0, d, want_c;
    logic [255:0] e, a, b;
    e = 256'h0123_4567_89AB_CDEF_0000_0000_0000_0007; a = 256'h00F0_0000_0000_0000_0000_0000_0000_1000; b = 256'h5555_0000;
    b0 = beats.size(); l0 = loads.size(); r0 = rds_c.size(); dn0 = done_c.size();
    do_req(1, 2'd1, e, a, b, gc);
    wait_beats(b0 + 4, 200);
    n_vec++; if (loads[l0].c != gc + 1 || loads[l0].addr !== 2'd0 || loads[l0].en !== 1'b0 || loads[l0].base !== 1'b0 || loads[l0].win !== a) begin n_err++; $display("FAIL sm_load0 got cyc %0d addr %0d en %b win %h, required cyc %0d addr 0 en 0 win a", loads[l0].c, loads[l0].addr, loads[l0].en, loads[l0].win, gc + 1); end
    n_vec++; if (loads[l0+1].c != gc + 2 || loads[l0+1].addr !== 2'd1 || loads[l0+1].en !== 1'b1 || loads[l0+1].win !== b) begin n_err++; $display("FAIL sm_load1 got cyc %0d addr %0d en %b win %h, required cyc %0d addr 1 en 1 win b", loads[l0+1].c, loads[l0+1].addr, loads[l0+1].en, loads[l0+1].win, gc + 2); end
    d = done_c[dn0];
    n_vec++; if (rds_c.size() != r0 + 4) begin n_err++; $display("FAIL sm_rd_count got %0d, required 4", rds_c.size() - r0); end
    for (int k = 0; k < 4; k++) begin
      want_c = (k == 0) ? d + 1 : beats[b0+k-1].c + 1;
      n_vec++; if (rds_c[r0+k] != want_c || rds_a[r0+k] !== 2'(k)) begin n_err++; $display("FAIL sm_rd%0d got cyc %0d addr %0d, required cyc %0d addr %0d", k, rds_c[r0+k], rds_a[r0+k], want_c, k); end
      n_vec++; if (beats[b0+k].start != want_c + 1 + L) begin n_err++; $display("FAIL sm_beat%0d_timing got %0d, required %0d", k, beats[b0+k].start, want_c + 1 + L); end
      n_vec++; if (beats[b0+k].d !== e + a + b + 256'(k) || beats[b0+k].id !== 1'b1 || beats[b0+k].last !== (k == 3) || beats[b0+k].err !== 1'b0) begin n_err++; $display("FAIL sm_beat%0d got id %b last %b data %h, required id 1 last %b data %h", k, beats[b0+k].id, beats[b0+k].last, beats[b0+k].d, k == 3, e + a + b + 256'(k)); end
    end
    n_vec++; if (last_cycles !== 32'd10) begin n_err++; $display("FAIL sm_last_cycles got %0d, required 10", last_cycles); end
  endtask

  task automatic test_round_robin();
    int g0, b0, l0;
    logic [255:0] e0, a0, e1, a1, want;
    logic wid;
    e0 = 256'h1000; a0 = 256'h20; e1 = 256'h7_0000; a1 = 256'h300;
    g0 = grant_c.size(); b0 = beats.size(); l0 = loads.size();
    req_cmd = {2'd2, 2'd2}; req_e[0] = e0; req_a[0] = a0; req_e[1] = e1; req_a[1] = a1;
    req_b = '0; req_valid = 2'b11;
    for (int n = 0; n < 600 && grant_c.size() < g0 + 4; n++) tick();
    req_valid = 2'b00;
    n_vec++; if (grant_c.size() < g0 + 4) begin n_err++; $display("FAIL rr_grants got %0d, required 4", grant_c.size() - g0); end
    wait_beats(b0 + 16, 300);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (grant_id[g0+i] !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_grant%0d got %b, required %b", i, grant_id[g0+i], i % 2 == 1); end
      n_vec++; if (loads[l0+i].base !== 1'b1) begin n_err++; $display("FAIL rr_base_en%0d got %b, required 1", i, loads[l0+i].base); end
    end
    for (int k = 0; k < 16; k++) begin
      wid = ((k / 4) % 2 == 1);
      want = (wid ? e1 + a1 : e0 + a0) + 256'(k % 4);
      n_vec++; if (beats[b0+k].id !== wid || beats[b0+k].d !== want || beats[b0+k].last !== (k % 4 == 3)) begin n_err++; $display("FAIL rr_beat%0d got id %b data %h, required id %b data %h", k, beats[b0+k].id, beats[b0+k].d, wid, want); end
    end
  endtask

  task automatic test_illegal();
    int gc, b0, s0;
    b0 = beats.size(); s0 = strobe_hits;
    do_req(0, 2'd3, 256'd77, 256'd55, 256'd0, gc);
    wait_beats(b0 + 1, 50);
    n_vec++; if (strobe_hits != s0) begin n_err++; $display("FAIL ill_strobes got %0d strobe cycles, required 0", strobe_hits - s0); end
    n_vec++; if ({beats[b0].id, beats[b0].last, beats[b0].err} !== 3'b011 || beats[b0].d !== 256'd0) begin n_err++; $display("FAIL ill_beat got id/last/err %b data %h, required 011 data 0", {beats[b0].id, beats[b0].last, beats[b0].err}, beats[b0].d); end
    n_vec++; if (beats[b0].start != gc + 2) begin n_err++; $display("FAIL ill_timing got %0d, required %0d", beats[b0].start, gc + 2); end
    n_vec++; if (last_cycles !== 32'd9) begin n_err++; $display("FAIL ill_last_cycles got %0d, required 9", last_cycles); end
  endtask

  task automatic test_backpressure();
    int gc, b0, r0, r_now, unstable;
    logic [255:0] e, a;
    e = 256'hABC0_0000; a = 256'h0DEF;
    b0 = beats.size(); r0 = rds_c.size();
    rsp_ready = 1'b0;
    do_req(1, 2'd2, e, a, 256'd0, gc);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== e + a) begin n_err++; $display("FAIL bp_first got valid %b data %h, required 1 %h", rsp_valid, rsp_data, e + a); end
    r_now = rds_c.size(); unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== e + a || rsp_last !== 1'b0 || rsp_id !== 1'b1) unstable++;
    end
    n_vec++; if (unstable != 0) begin n_err++; $display("FAIL bp_stable got %0d unstable cycles, required 0", unstable); end
    n_vec++; if (r_now != r0 + 1 || rds_c.size() != r0 + 1) begin n_err++; $display("FAIL bp_no_rd got %0d reads, required 1", rds_c.size() - r0); end
    tick();
    rsp_ready = 1'b1;
    wait_beats(b0 + 4, 100);
    n_vec++; if (beats[b0].c < beats[b0].start + 10 || rds_c[r0+1] != beats[b0].c + 1) begin n_err++; $display("FAIL bp_resume got hs %0d rd %0d, required rd at hs+1", beats[b0].c, rds_c[r0+1]); end
    for (int k = 1; k < 4; k++) begin
      n_vec++; if (beats[b0+k].d !== e + a + 256'(k)) begin n_err++; $display("FAIL bp_beat%0d got %h, required %h", k, beats[b0+k].d, e + a + 256'(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int gc0, gc1, b0;
    b0 = beats.size();
    do_req(0, 2'd0, 256'h42, 256'h99, 256'd0, gc0);
    req_cmd[1] = 2'd3; req_valid[1] = 1'b1; gc1 = -1;
    for (int n = 0; n < 100 && gc1 < 0; n++) begin
      @(negedge clk);
      if (req_ready[1]) gc1 = cyc;
      tick();
    end
    req_valid[1] = 1'b0;
    wait_beats(b0 + 2, 50);
    n_vec++; if (gc1 != beats[b0].c + 1) begin n_err++; $display("FAIL b2b_grant got cyc %0d, required %0d", gc1, beats[b0].c + 1); end
    n_vec++; if (beats[b0].d !== (256'h42 ^ 256'h99 ^ DH_K) || beats[b0+1].id !== 1'b1 || beats[b0+1].err !== 1'b1) begin n_err++; $display("FAIL b2b_beats got %h id %b err %b, required dh data then id 1 err 1", beats[b0].d, beats[b0+1].id, beats[b0+1].err); end
    n_vec++; if (last_cycles !== 32'd21) begin n_err++; $display("FAIL b2b_last_cycles got %0d, required 21", last_cycles); end
  endtask

  task automatic test_reset_mid();
    int gc, b0, r0;
    logic [255:0] e2, a2;
    e2 = 256'h3_0000_0000; a2 = 256'h44;
    b0 = beats.size(); r0 = rds_c.size();
    do_req(1, 2'd1, 256'h11, 256'h22, 256'h33, gc);
    repeat (3) @(posedge clk);
    #2;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before got %b, required 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, rsp_valid, core_dh_en, core_dsa_en, core_dsa_base_en, core_dsa_load, core_dsa_rd} !== 7'd0) begin n_err++; $display("FAIL rst_mid_ctrl got nonzero, required 0"); end
    n_vec++; if (last_cycles !== 32'd0 || core_e !== 256'd0 || core_work_in !== 256'd0) begin n_err++; $display("FAIL rst_mid_data got last_cycles %0d, required 0 and zero core bus", last_cycles); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (5) tick();
    n_vec++; if (busy !== 1'b0 || rds_c.size() != r0 || beats.size() != b0) begin n_err++; $display("FAIL rst_stale_done got busy %b reads %0d beats %0d, required 0 0 0", busy, rds_c.size() - r0, beats.size() - b0); end
    do_req(1, 2'd2, e2, a2, 256'd0, gc);
    wait_beats(b0 + 4, 100);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (beats[b0+k].d !== e2 + a2 + 256'(k) || beats[b0+k].id !== 1'b1) begin n_err++; $display("FAIL rst_next_beat%0d got %h, required %h", k, beats[b0+k].d, e2 + a2 + 256'(k)); end
    end
    n_vec++; if (last_cycles !== 32'd9) begin n_err++; $display("FAIL rst_next_last_cycles got %0d, required 9", last_cycles); end
    n_vec++; if (doubles != 0) begin n_err++; $display("FAIL strobe_width got %0d multi-cycle strobes, required 0", doubles); end
  endtask

  initial begin
    req_valid = 2'b00; req_cmd = '0; req_e = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; inj_done = 1'b0; rst_n = 1'b0;
    test_reset();
    test_dh();
    test_scalarmult();
    test_round_robin();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
